// File: rtl/console_pkg.sv
// Shared definitions for the console top level: reset sequencer state
// encoding, default 25 MHz timing constants and a small sizing helper.
package console_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    STAGE = 2'd1,
    RUN   = 2'd2
  } rst_seq_state_t;

  // 0.062 s power-on hold at 25 MHz
  localparam int POR_CYCLES_25MHZ = 1562500;
  // 10 ms stable-low requirement for board buttons at 25 MHz
  localparam int DEBOUNCE_25MHZ   = 250000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stable-count
// debouncer. level is the debounced button level (1 = released) and press
// is a one-cycle pulse issued together with a debounced released->pressed
// change. Also intended for the joypad buttons.
module rst_debounce
  import console_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_25MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] stable_cnt;

  // Bring the asynchronous button into the clk domain; idle level is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= btn_n;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has been seen DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level      <= 1'b1;
      press      <= 1'b0;
      stable_cnt <= '0;
    end else begin
      press <= 1'b0;
      if (sync_b == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == LAST) begin
        level      <= sync_b;
        press      <= ~sync_b;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / re-triggerable reset sequencer. Holds every downstream domain in
// reset for POR_CYCLES, then releases the channels in order 0..N_CH-1, each
// after at least STAGE_CYCLES and its ready acknowledge, or after
// TIMEOUT_CYCLES without one (flagged in the sticky fault vector). A
// debounced button press or sw_rst_req restarts the whole sequence.
module reset_sequencer
  import console_pkg::*;
#(
  parameter int N_CH            = 3,
  parameter int POR_CYCLES      = POR_CYCLES_25MHZ,
  parameter int STAGE_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES  = 65536,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_25MHZ
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ext_rst_n,
  input  logic            sw_rst_req,
  input  logic [N_CH-1:0] ready,
  output logic [N_CH-1:0] run,
  output logic            done,
  output logic [N_CH-1:0] fault
);

  localparam int CNT_W = $clog2(max3(POR_CYCLES, TIMEOUT_CYCLES, DEBOUNCE_CYCLES) + 1);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_CH - 1);

  rst_seq_state_t   state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [N_CH-1:0]  run_next;
  logic             done_next;
  logic [N_CH-1:0]  fault_next;
  logic             advance;
  logic             btn_level;
  logic             btn_press;
  logic             trigger;

  rst_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .btn_n (ext_rst_n),
    .level (btn_level),
    .press (btn_press)
  );

  assign trigger = btn_press | sw_rst_req;

  // State, dwell counter, channel index and all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HOLD;
      cnt   <= '0;
      idx   <= '0;
      run   <= '0;
      done  <= 1'b0;
      fault <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      run   <= run_next;
      done  <= done_next;
      fault <= fault_next;
    end
  end

  // Next-state logic; a restart trigger takes priority over any advance.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    run_next   = run;
    done_next  = done;
    fault_next = fault;
    advance    = 1'b0;

    if (trigger) begin
      state_next = HOLD;
      cnt_next   = '0;
      idx_next   = '0;
      run_next   = '0;
      done_next  = 1'b0;
      fault_next = '0;
    end else begin
      case (state)
        HOLD: begin
          run_next = '0;
          if (!btn_level) begin
            // button still held down: POR interval starts after release
            cnt_next = '0;
          end else if (cnt == POR_LAST) begin
            run_next[0] = 1'b1;
            cnt_next    = '0;
            idx_next    = '0;
            state_next  = STAGE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        STAGE: begin
          if (ready[idx] && (cnt >= STAGE_LAST)) begin
            advance = 1'b1;
          end else if (!ready[idx] && (cnt == TO_LAST)) begin
            advance         = 1'b1;
            fault_next[idx] = 1'b1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
          if (advance) begin
            cnt_next = '0;
            if (idx == IDX_LAST) begin
              done_next  = 1'b1;
              state_next = RUN;
            end else begin
              run_next[idx + IDX_W'(1)] = 1'b1;
              idx_next                  = idx + IDX_W'(1);
            end
          end
        end
        RUN: begin
          cnt_next = '0;
        end
        default: begin
          state_next = HOLD;
          cnt_next   = '0;
          idx_next   = '0;
          run_next   = '0;
          done_next  = 1'b0;
          fault_next = '0;
        end
      endcase
    end
  end

endmodule
